// File: rtl/conv3x3_stage_pkg.sv
// Shared types, widths and constants for the 3x3 convolution stage.
package conv3x3_stage_pkg;

  localparam int unsigned IMG_W_DEF   = 256;
  localparam int unsigned IMG_H_DEF   = 256;
  localparam int unsigned PIX_W       = 8;
  localparam int unsigned PART_W      = 10;  // a+2b+c of 8-bit pixels, max 1020
  localparam int unsigned GRAD_W      = 11;  // signed gradient, +-1020
  localparam int unsigned SUM_W       = 12;  // Gaussian sum, max 4080
  localparam int unsigned RND_W       = SUM_W + 1;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned GAUSS_RND   = 8;
  localparam int unsigned GAUSS_SHIFT = 4;
  localparam int unsigned SAT_MAX     = 255;

  typedef enum logic {
    MODE_GAUSS = 1'b0,
    MODE_SOBEL = 1'b1
  } mode_e;

  // Stage-1 payload: three row sums, two column sums, mode tag.
  typedef struct packed {
    logic [PART_W-1:0] row_top;
    logic [PART_W-1:0] row_mid;
    logic [PART_W-1:0] row_bot;
    logic [PART_W-1:0] col_lft;
    logic [PART_W-1:0] col_rgt;
    mode_e             mode;
  } part_t;

  // Stage-2 payload: Gaussian sum or Sobel magnitude, mode tag.
  typedef struct packed {
    logic [SUM_W-1:0] val;
    mode_e            mode;
  } sum_t;

  // 1-2-1 weighted sum of three pixels.
  function automatic logic [PART_W-1:0] wsum(input logic [PIX_W-1:0] a,
                                             input logic [PIX_W-1:0] b,
                                             input logic [PIX_W-1:0] c);
    return PART_W'(a) + PART_W'({b, 1'b0}) + PART_W'(c);
  endfunction

endpackage

// File: rtl/conv3x3_stage_if.sv
// Window input / filtered pixel output bundle.
// master: window source + frame control; slave: the filter stage.
interface conv3x3_stage_if;
  import conv3x3_stage_pkg::*;

  logic             in_valid;
  logic [PIX_W-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic             mode;
  logic             frame_start;
  logic             out_valid;
  logic [PIX_W-1:0] pix_out;
  logic             frame_done;
  logic             busy;

  modport master (
    output in_valid, p1, p2, p3, p4, p5, p6, p7, p8, p9, mode, frame_start,
    input  out_valid, pix_out, frame_done, busy
  );

  modport slave (
    input  in_valid, p1, p2, p3, p4, p5, p6, p7, p8, p9, mode, frame_start,
    output out_valid, pix_out, frame_done, busy
  );

endinterface

// File: rtl/conv3x3_stage_pix_sat.sv
// Saturate an unsigned 12-bit value to 8 bits.
// Ports: val (12b in), sat_c (8b out, combinational).
module pix_sat
  import conv3x3_stage_pkg::*;
(
  input  logic [SUM_W-1:0] val,
  output logic [PIX_W-1:0] sat_c
);

  assign sat_c = (val > SUM_W'(SAT_MAX)) ? PIX_W'(SAT_MAX) : val[PIX_W-1:0];

endmodule

// File: rtl/conv3x3_stage.sv
// 3-stage 3x3 Gaussian blur / Sobel magnitude filter with frame pixel counter.
// Ports: clk, rst (async, active-high), bus (conv3x3_stage_if.slave):
//   in_valid/p1..p9/mode in, frame_start in, out_valid/pix_out/frame_done/busy out.
module conv3x3_stage
  import conv3x3_stage_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input  logic             clk,
  input  logic             rst,
  conv3x3_stage_if.slave   bus
);

  localparam int unsigned LAST_PIX = IMG_W * IMG_H - 1;

  logic                    v1, v2, v3;
  part_t                   part_c, s1;
  sum_t                    sum_c, s2;
  logic [SUM_W-1:0]        gauss_c;
  logic signed [GRAD_W-1:0] gx_c, gy_c;
  logic [GRAD_W-1:0]       ax_c, ay_c;
  logic [RND_W-1:0]        rnd_c;
  logic [SUM_W-1:0]        pre_sat_c;
  logic [PIX_W-1:0]        sat_c;
  logic [PIX_W-1:0]        pix_q;
  logic                    done_q;
  logic [CNT_W-1:0]        pix_cnt;
  logic                    last_c;

  // Stage 1 combinational: row and column partial sums.
  always_comb begin
    part_c         = '0;
    part_c.row_top = wsum(bus.p1, bus.p2, bus.p3);
    part_c.row_mid = wsum(bus.p4, bus.p5, bus.p6);
    part_c.row_bot = wsum(bus.p7, bus.p8, bus.p9);
    part_c.col_lft = wsum(bus.p1, bus.p4, bus.p7);
    part_c.col_rgt = wsum(bus.p3, bus.p6, bus.p9);
    part_c.mode    = mode_e'(bus.mode);
  end

  // Stage 2 combinational: full Gaussian sum, or |gx|+|gy|.
  always_comb begin
    gauss_c   = SUM_W'(s1.row_top) + SUM_W'({s1.row_mid, 1'b0}) + SUM_W'(s1.row_bot);
    gx_c      = $signed(GRAD_W'(s1.col_rgt)) - $signed(GRAD_W'(s1.col_lft));
    gy_c      = $signed(GRAD_W'(s1.row_bot)) - $signed(GRAD_W'(s1.row_top));
    ax_c      = gx_c[GRAD_W-1] ? $unsigned(-gx_c) : $unsigned(gx_c);
    ay_c      = gy_c[GRAD_W-1] ? $unsigned(-gy_c) : $unsigned(gy_c);
    sum_c     = '0;
    sum_c.val = (s1.mode == MODE_SOBEL) ? SUM_W'(ax_c) + SUM_W'(ay_c) : gauss_c;
    sum_c.mode = s1.mode;
  end

  // Stage 3 combinational: Gaussian rounding, then shared saturation.
  always_comb begin
    rnd_c     = RND_W'(s2.val) + RND_W'(GAUSS_RND);
    pre_sat_c = (s2.mode == MODE_GAUSS) ? SUM_W'(rnd_c >> GAUSS_SHIFT) : s2.val;
  end

  pix_sat u_pix_sat (
    .val   (pre_sat_c),
    .sat_c (sat_c)
  );

  assign last_c = (pix_cnt == CNT_W'(LAST_PIX));

  // Pipeline registers; mode travels with its window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      s1     <= '0;
      s2     <= '0;
      pix_q  <= '0;
      done_q <= 1'b0;
    end else begin
      v1     <= bus.in_valid;
      v2     <= v1;
      v3     <= v2;
      if (bus.in_valid) s1 <= part_c;
      if (v1)           s2 <= sum_c;
      pix_q  <= v2 ? sat_c : '0;
      done_q <= v2 && last_c;
    end
  end

  // Pixel counter; an idle-only frame_start never races a counted pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= '0;
    end else if (v2) begin
      pix_cnt <= last_c ? '0 : pix_cnt + CNT_W'(1);
    end else if (bus.frame_start && !bus.busy) begin
      pix_cnt <= '0;
    end
  end

  assign bus.out_valid  = v3;
  assign bus.pix_out    = pix_q;
  assign bus.frame_done = done_q;
  assign bus.busy       = v1 | v2 | v3;

endmodule

// File: tb/tb_conv3x3_stage.sv
// Scoreboard bench for conv3x3_stage: directed windows, mode alternation,
// reset flush, full-frame wrap and frame_start handling.
module tb_conv3x3_stage;
  import conv3x3_stage_pkg::*;

  localparam int unsigned W    = 256;
  localparam int unsigned H    = 256;
  localparam int unsigned LAST = W * H - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv3x3_stage_if bus ();

  conv3x3_stage #(.IMG_W(W), .IMG_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] pix;
    logic       done;
    longint     due;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned passes = 0;
  longint      cyc = 0;
  int unsigned exp_cnt = 0;
  int unsigned done_seen = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference straight from the filter equations.
  function automatic int model(input logic [71:0] win, input logic m);
    int p[9];
    int s, gx, gy;
    for (int i = 0; i < 9; i++) p[i] = int'(win[71-8*i -: 8]);
    if (m == 1'b0) begin
      s = p[0] + 2*p[1] + p[2] + 2*p[3] + 4*p[4] + 2*p[5] + p[6] + 2*p[7] + p[8];
      s = (s + 8) >> 4;
    end else begin
      gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
      gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
      s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    end
    return (s > 255) ? 255 : s;
  endfunction

  // Monitor: pop and compare on every out_valid; idle outputs must be zero.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (bus.out_valid) begin
        if (bus.frame_done) done_seen++;
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("pix_out", bus.pix_out, e.pix);
          check("frame_done", bus.frame_done, e.done);
          check("latency", cyc, e.due);
        end
      end else begin
        check("idle_outputs", {bus.frame_done, bus.pix_out}, 0);
      end
    end
  end

  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic send(input logic [71:0] win, input logic m, input int expv);
    exp_t e;
    {bus.p1, bus.p2, bus.p3, bus.p4, bus.p5, bus.p6, bus.p7, bus.p8, bus.p9} = win;
    bus.mode     = m;
    bus.in_valid = 1'b1;
    e.pix  = 8'(expv);
    e.done = (exp_cnt == LAST);
    e.due  = cyc + 3;
    sb.push_back(e);
    exp_cnt = e.done ? 0 : exp_cnt + 1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [71:0] rand_win();
    return 72'({$urandom(), $urandom(), $urandom()});
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [71:0] w;
    logic        m;
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.frame_start = 1'b0;
    bus.mode        = 1'b0;
    {bus.p1, bus.p2, bus.p3, bus.p4, bus.p5, bus.p6, bus.p7, bus.p8, bus.p9} = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.busy, bus.out_valid, bus.frame_done, bus.pix_out}, 0);
    check("reset_counter", dut.pix_cnt, 0);
    rst = 1'b0;
    idle(2);

    // Directed vectors with hand-computed results.
    send({9{8'd100}}, MODE_GAUSS, 100);
    idle(5);
    send({32'd0, 8'd255, 32'd0}, MODE_GAUSS, 64);
    send({9{8'd255}}, MODE_GAUSS, 255);
    send({8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255}, MODE_SOBEL, 255);
    send({9{8'd77}}, MODE_SOBEL, 0);
    send({48'd0, 8'd10, 8'd10, 8'd10}, MODE_SOBEL, 40);
    idle(5);

    // Mode toggles every window; each result follows its own mode.
    for (int i = 0; i < 10; i++) begin
      w = rand_win();
      m = 1'(i % 2);
      send(w, m, model(w, m));
    end
    idle(5);

    // Reset with two windows in flight discards them.
    send(rand_win(), MODE_GAUSS, 0);
    send(rand_win(), MODE_SOBEL, 0);
    check("busy_in_flight", bus.busy, 1);
    rst = 1'b1;
    #1;
    sb.delete();
    exp_cnt = 0;
    check("reset_flush", {bus.busy, bus.out_valid, bus.pix_out}, 0);
    check("reset_flush_counter", dut.pix_cnt, 0);
    idle(2);
    rst = 1'b0;
    idle(6);

    // Full frame with random gaps; first window after reset is pixel 0.
    for (int n = 0; n < 65536; n++) begin
      if ($urandom_range(0, 15) == 0) idle(1);
      w = rand_win();
      m = 1'($urandom_range(0, 1));
      send(w, m, model(w, m));
    end
    idle(6);
    check("frame_done_count", done_seen, 1);
    check("counter_after_frame", dut.pix_cnt, 0);

    // frame_start while busy is ignored.
    for (int i = 0; i < 3; i++) send({9{8'd100}}, MODE_GAUSS, 100);
    idle(6);
    check("counter_three", dut.pix_cnt, 3);
    send({9{8'd255}}, MODE_GAUSS, 255);
    check("busy_before_start", bus.busy, 1);
    bus.frame_start = 1'b1;
    idle(1);
    bus.frame_start = 1'b0;
    idle(5);
    check("frame_start_busy_ignored", dut.pix_cnt, exp_cnt);

    // frame_start while idle clears the counter.
    check("idle_before_start", bus.busy, 0);
    bus.frame_start = 1'b1;
    idle(1);
    bus.frame_start = 1'b0;
    exp_cnt = 0;
    check("frame_start_idle_clear", dut.pix_cnt, 0);
    send({9{8'd100}}, MODE_GAUSS, 100);
    idle(6);
    check("counter_after_clear", dut.pix_cnt, 1);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/conv3x3_stage.md
CONV3X3_STAGE -- requirements
Module: conv3x3_stage

Interface
REQ-001 Parameter IMG_W, default 256, pixels per output row.
REQ-002 Parameter IMG_H, default 256, output rows per frame.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  window p1..p9 valid this cycle (upstream read strobe delayed one cycle).
REQ-006 p1..p9  input  8 each  3x3 window, row-major; p1 top-left, p5 centre, p9 bottom-right.
REQ-007 mode  input  1  0 = Gaussian blur, 1 = Sobel magnitude.
REQ-008 frame_start  input  1  single-cycle request to clear the pixel counter.
REQ-009 out_valid  output  1  pix_out valid; drives the write strobe of the downstream frame memory.
REQ-010 pix_out  output  8  filtered pixel.
REQ-011 frame_done  output  1  one-cycle pulse with the last pixel of a frame.
REQ-012 busy  output  1  high while any pipeline stage holds a valid window.

Function
REQ-013 Fixed 3-stage pipeline, no stalls; a window accepted at edge N SHALL appear with out_valid=1 at edge N+3.
REQ-014 mode SHALL be captured with its window in stage 1 and travel with it; a mode change applies only to windows accepted after the change, so a mid-stream change never corrupts in-flight pixels.
REQ-015 Gaussian: S = p1+2p2+p3+2p4+4p5+2p6+p7+2p8+p9 (unsigned, 12 bits, max 4080); pix_out = (S+8)>>4, clamped to 255.
REQ-016 Sobel: gx = (p3+2p6+p9)-(p1+2p4+p7), gy = (p7+2p8+p9)-(p1+2p2+p3), each signed 11 bits (±1020); pix_out = min(|gx|+|gy|, 255).
REQ-017 Stage 1: row/column partial sums. Stage 2: full sums and absolute values. Stage 3: round/saturate into the output register.
REQ-018 When out_valid=0, pix_out SHALL be 0.
REQ-019 A 16-bit pixel counter SHALL increment on every out_valid cycle.
REQ-020 On the out_valid cycle where the counter equals IMG_W*IMG_H-1, frame_done SHALL be 1 and the counter SHALL wrap to 0.
REQ-021 frame_start with busy=0 SHALL clear the counter to 0 at the next edge.
REQ-022 frame_start with busy=1 SHALL be ignored.
REQ-023 in_valid gaps are legal; bubbles propagate unchanged and do not advance the counter.
REQ-024 busy = OR of the stage-1..3 valid flags.

Reset
REQ-025 Asserting rst SHALL immediately clear all valid flags, the counter, out_valid, pix_out, frame_done and busy to 0, discarding any in-flight windows.
REQ-026 The first window accepted after rst deasserts SHALL be counted as pixel 0.

Structure
REQ-027 A shared package SHALL hold: IMG_W/IMG_H defaults, the mode encoding (MODE_GAUSS=0, MODE_SOBEL=1), the Gaussian rounding constant 8 and shift 4, and the output saturation limit 255.
REQ-028 One sub-module, pix_sat, SHALL take an unsigned 12-bit value and return min(value, 255) as 8 bits; it is used by both modes in stage 3.

Verification
REQ-029 Gaussian, all p=100, one in_valid pulse: exactly 3 cycles later out_valid=1, pix_out=100; otherwise pix_out=0.
REQ-030 Gaussian, p5=255 and the rest 0: pix_out=64. All p=255: pix_out=255.
REQ-031 Sobel, p3=p6=p9=255 and the rest 0: gx=1020, gy=0, pix_out=255. All p=77: pix_out=0. p7=p8=p9=10, rest 0: pix_out=40.
REQ-032 Alternate mode every cycle over 10 back-to-back windows; each output SHALL match the mode sampled with its own window.
REQ-033 Drive 65536 windows with random gaps: 65536 out_valid cycles; a single frame_done on the last one; counter=0 afterwards.
REQ-034 Assert rst while 2 windows are in flight: no out_valid follows. frame_start at busy=1 leaves the counter unchanged; at busy=0 it clears the counter.
